updown_ctrl: RTL and testbench

UPDOWN_CTRL -- requirements
Module: updown_ctrl

---
 rtl/updown_ctrl.sv | 101 ++++++++++
 tb/tb_updown_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_ctrl.sv
// Up/down counter with IDLE/UP/DOWN mode FSM, synchronous load and terminal-count flag.
// Define UPDOWN_SAT_EN to clamp at the range ends instead of wrapping.
module updown_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             up,
  input  logic             dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       mode,
  output logic             tc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] q_d;
  logic             tc_d;
  logic             at_max;
  logic             at_min;

  assign mode   = state_q;
  assign at_max = (q == {WIDTH{1'b1}});
  assign at_min = (q == {WIDTH{1'b0}});

  // State, count and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      q       <= '0;
      tc      <= 1'b0;
    end else begin
      state_q <= state_d;
      q       <= q_d;
      tc      <= tc_d;
    end
  end

  // Mode selection; the illegal encoding falls back to IDLE unconditionally
  always_comb begin
    state_d = state_q;
    if (state_q == ST_BAD) begin
      state_d = ST_IDLE;
    end else if (ena) begin
      if (load)           state_d = ST_IDLE;
      else if (up && dn)  state_d = ST_IDLE;
      else if (up)        state_d = ST_UP;
      else if (dn)        state_d = ST_DOWN;
    end
  end

  // Count step follows the registered mode, so a new request counts one cycle later
  always_comb begin
    q_d  = q;
    tc_d = 1'b0;
    if (ena) begin
      if (load) begin
        q_d = load_val;
      end else begin
        case (state_q)
          ST_UP: begin
            if (at_max) begin
              tc_d = 1'b1;
`ifdef UPDOWN_SAT_EN
              q_d  = q;
`else
              q_d  = '0;
`endif
            end else begin
              q_d = q + WIDTH'(1);
            end
          end
          ST_DOWN: begin
            if (at_min) begin
              tc_d = 1'b1;
`ifdef UPDOWN_SAT_EN
              q_d  = q;
`else
              q_d  = {WIDTH{1'b1}};
`endif
            end else begin
              q_d = q - WIDTH'(1);
            end
          end
          default: q_d = q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updown_ctrl.sv
// Self-checking bench for updown_ctrl: directed scenarios plus randomized traffic
// against an arithmetic reference model (honours UPDOWN_SAT_EN if defined).
module tb_updown_ctrl;
  localparam int unsigned WIDTH = 4;
  localparam int MAXV = (1 << WIDTH) - 1;

  logic             clk;
  logic             reset;
  logic             ena;
  logic             up;
  logic             dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [1:0]       mode;
  logic             tc;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: count as plain integer, mode as 0 idle / 1 up / 2 down
  int m_q;
  int m_mode;
  int m_tc;

  updown_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .up       (up),
    .dn       (dn),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .mode     (mode),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_q = 0; m_mode = 0; m_tc = 0;
  endtask

  task automatic model_edge(input bit e, input bit u, input bit d, input bit l, input int lv);
    int nq;
    int nm;
    int ntc;
    nq = m_q; nm = m_mode; ntc = 0;
    if (e) begin
      if (l) begin
        nq = lv % (MAXV + 1);
        nm = 0;
      end else begin
        if (m_mode == 1) nq = m_q + 1;
        if (m_mode == 2) nq = m_q - 1;
        if (nq > MAXV || nq < 0) begin
          ntc = 1;
`ifdef UPDOWN_SAT_EN
          nq = m_q;
`else
          nq = (nq + MAXV + 1) % (MAXV + 1);
`endif
        end
        if (u && d)  nm = 0;
        else if (u)  nm = 1;
        else if (d)  nm = 2;
      end
    end
    m_q = nq; m_mode = nm; m_tc = ntc;
  endtask

  task automatic drive_cycle(input bit e, input bit u, input bit d, input bit l, input int lv);
    ena = e; up = u; dn = d; load = l; load_val = WIDTH'(lv);
    model_edge(e, u, d, l, lv);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ena = 1'b1; up = 1'b1; dn = 1'b0; load = 1'b1; load_val = WIDTH'(9);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (q !== 0 || mode !== 2'b00 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: q=%0d mode=%0d tc=%0d, want q=0 mode=0 tc=0", q, mode, tc);
    end
    ena = 0; up = 0; dn = 0; load = 0; load_val = '0;
    reset = 1'b0;
    model_reset();
    drive_cycle(1, 0, 0, 0, 0);
    n_checks++;
    if (q !== 0 || mode !== 2'b00 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: q=%0d mode=%0d tc=%0d, want q=0 mode=0 tc=0", q, mode, tc);
    end
  endtask

  task automatic test_up_wrap();
    int exp_q[4];
    int exp_tc[4];
`ifdef UPDOWN_SAT_EN
    exp_q  = '{14, 15, 15, 15};
    exp_tc = '{0, 0, 1, 1};
`else
    exp_q  = '{14, 15, 0, 1};
    exp_tc = '{0, 0, 1, 0};
`endif
    drive_cycle(1, 0, 0, 1, 14);
    n_checks++;
    if (q !== 14 || mode !== 2'b00 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL up_load: q=%0d mode=%0d tc=%0d, want q=14 mode=0 tc=0", q, mode, tc);
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 1, 0, 0, 0);
      n_checks++;
      if (q !== WIDTH'(exp_q[i]) || mode !== 2'b01 || tc !== exp_tc[i][0]) begin
        n_fail++;
        $display("FAIL up_edge%0d: q=%0d mode=%0d tc=%0d, want q=%0d mode=1 tc=%0d",
                 i + 1, q, mode, tc, exp_q[i], exp_tc[i]);
      end
    end
  endtask

  task automatic test_down_wrap();
    int exp_q[3];
    int exp_tc[3];
`ifdef UPDOWN_SAT_EN
    exp_q  = '{1, 0, 0};
`else
    exp_q  = '{1, 0, 15};
`endif
    exp_tc = '{0, 0, 1};
    drive_cycle(1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 0, 1, 0, 0);
      n_checks++;
      if (q !== WIDTH'(exp_q[i]) || mode !== 2'b10 || tc !== exp_tc[i][0]) begin
        n_fail++;
        $display("FAIL down_edge%0d: q=%0d mode=%0d tc=%0d, want q=%0d mode=2 tc=%0d",
                 i + 1, q, mode, tc, exp_q[i], exp_tc[i]);
      end
    end
  endtask

  task automatic test_updn_conflict();
    drive_cycle(1, 0, 0, 1, 4);
    drive_cycle(1, 1, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0);
    n_checks++;
    if (q !== 5 || mode !== 2'b01) begin
      n_fail++;
      $display("FAIL updn_setup: q=%0d mode=%0d, want q=5 mode=1", q, mode);
    end
    drive_cycle(1, 1, 1, 0, 0);
    n_checks++;
    if (q !== 6 || mode !== 2'b00 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL updn_step: q=%0d mode=%0d tc=%0d, want q=6 mode=0 tc=0", q, mode, tc);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1, 0, 0, 0, 0);
      n_checks++;
      if (q !== 6 || mode !== 2'b00 || tc !== 1'b0) begin
        n_fail++;
        $display("FAIL updn_hold%0d: q=%0d mode=%0d tc=%0d, want q=6 mode=0 tc=0", i, q, mode, tc);
      end
    end
  endtask

  task automatic test_ena_freeze();
    int hold;
`ifdef UPDOWN_SAT_EN
    hold = 0;
`else
    hold = 15;
`endif
    drive_cycle(1, 0, 0, 1, 0);
    drive_cycle(1, 0, 1, 0, 0);
    drive_cycle(1, 0, 1, 0, 0);
    n_checks++;
    if (q !== WIDTH'(hold) || mode !== 2'b10 || tc !== 1'b1) begin
      n_fail++;
      $display("FAIL freeze_setup: q=%0d mode=%0d tc=%0d, want q=%0d mode=2 tc=1", q, mode, tc, hold);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 1, 0, 1, 9);
      n_checks++;
      if (q !== WIDTH'(hold) || mode !== 2'b10 || tc !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze%0d: q=%0d mode=%0d tc=%0d, want q=%0d mode=2 tc=0", i, q, mode, tc, hold);
      end
    end
    drive_cycle(1, 0, 0, 1, 9);
    n_checks++;
    if (q !== 9 || mode !== 2'b00 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_load: q=%0d mode=%0d tc=%0d, want q=9 mode=0 tc=0", q, mode, tc);
    end
  endtask

  task automatic test_reset_midcount();
    drive_cycle(1, 0, 0, 1, 6);
    drive_cycle(1, 1, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0);
    n_checks++;
    if (q !== 7 || mode !== 2'b01) begin
      n_fail++;
      $display("FAIL midreset_setup: q=%0d mode=%0d, want q=7 mode=1", q, mode);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (q !== 0 || mode !== 2'b00 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: q=%0d mode=%0d tc=%0d, want q=0 mode=0 tc=0", q, mode, tc);
    end
    ena = 1; up = 1; dn = 0; load = 1; load_val = WIDTH'(12);
    @(posedge clk);
    #1;
    n_checks++;
    if (q !== 0 || mode !== 2'b00 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ignore: q=%0d mode=%0d tc=%0d, want q=0 mode=0 tc=0", q, mode, tc);
    end
    load = 0; up = 0;
    reset = 1'b0;
    drive_cycle(1, 0, 0, 0, 0);
    n_checks++;
    if (q !== 0 || mode !== 2'b00 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_release: q=%0d mode=%0d tc=%0d, want q=0 mode=0 tc=0", q, mode, tc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (q !== 0 || mode !== 2'b00 || tc !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_reset%0d: q=%0d mode=%0d tc=%0d, want 0 0 0", i, q, mode, tc);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
      end else begin
        drive_cycle($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 11) == 0, int'($urandom_range(0, MAXV)));
        n_checks++;
        if (q !== WIDTH'(m_q) || mode !== 2'(m_mode) || tc !== m_tc[0]) begin
          n_fail++;
          $display("FAIL rand_cycle%0d: q=%0d mode=%0d tc=%0d, want q=%0d mode=%0d tc=%0d",
                   i, q, mode, tc, m_q, m_mode, m_tc);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; ena = 0; up = 0; dn = 0; load = 0; load_val = '0;
    model_reset();
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_updn_conflict();
    test_ena_freeze();
    test_reset_midcount();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
